// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage
// ----------------------------------------------------------------------------
// Execute stage of the 5-stage MIPS pipeline. Resolves rs/rt forwarding from
// the EX/MEM register and the WB stage, runs the ALU, and owns an iterative
// shift-add MULT/MULTU unit with its HI/LO registers. Results are registered
// into the EX/MEM pipeline register. stall_ex asks the upstream stages to
// hold the RR/EX register while a multiply is in flight.
//
// Parameters
//   MUL_STEP           multiplier bits retired per BUSY cycle (1, 2, 4 or 8)
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   *_rr_ex            operands, register numbers, funct/ALUOp and control
//                      bits from the RR/EX register
//   RegWrite_mem_wb,
//   dstn_mem_wb,
//   Write_Data_wb      WB-stage write port, used as a forwarding source
//   *_ex_mem           registered EX/MEM outputs (result, store data,
//                      destination, control bits)
//   stall_ex           combinational hold request for RR/EX and upstream
// ============================================================================
module ex_stage #(
    parameter int MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Read_Data_1_rr_ex,
    input  logic [31:0] Read_Data_2_rr_ex,
    input  logic [31:0] extended_rr_ex,
    input  logic [4:0]  rs_rr_ex,
    input  logic [4:0]  rt_rr_ex,
    input  logic [4:0]  dstn_rr_ex,
    input  logic [5:0]  funct_rr_ex,
    input  logic [1:0]  ALUOp_rr_ex,
    input  logic        ALUSrc_rr_ex,
    input  logic        MemRead_rr_ex,
    input  logic        MemWrite_rr_ex,
    input  logic        MemtoReg_rr_ex,
    input  logic        RegWrite_rr_ex,
    input  logic        RegWrite_mem_wb,
    input  logic [4:0]  dstn_mem_wb,
    input  logic [31:0] Write_Data_wb,
    output logic [31:0] ALU_Result_ex_mem,
    output logic [31:0] Write_Data_ex_mem,
    output logic [4:0]  dstn_ex_mem,
    output logic        MemRead_ex_mem,
    output logic        MemWrite_ex_mem,
    output logic        MemtoReg_ex_mem,
    output logic        RegWrite_ex_mem,
    output logic        stall_ex
);

    localparam int MUL_ITER = 32 / MUL_STEP;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;

    mulState_t   state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] acc_q;
    logic        negate_q;
    logic [5:0]  count_q;

    logic [31:0] opA;
    logic [31:0] fwdB;
    logic [31:0] opB;
    logic [31:0] aluResult;
    logic        functValid;
    logic        isMult;
    logic        multSigned;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [63:0] acc_d;
    logic [63:0] product_d;

    // Operand forwarding. The EX/MEM result wins over WB because it is the
    // younger write; a load in EX/MEM has no data yet, so it is skipped.
    always_comb begin
        opA = Read_Data_1_rr_ex;
        if (RegWrite_ex_mem && !MemRead_ex_mem && (dstn_ex_mem != 5'd0) &&
            (dstn_ex_mem == rs_rr_ex)) begin
            opA = ALU_Result_ex_mem;
        end else if (RegWrite_mem_wb && (dstn_mem_wb != 5'd0) &&
                     (dstn_mem_wb == rs_rr_ex)) begin
            opA = Write_Data_wb;
        end

        fwdB = Read_Data_2_rr_ex;
        if (RegWrite_ex_mem && !MemRead_ex_mem && (dstn_ex_mem != 5'd0) &&
            (dstn_ex_mem == rt_rr_ex)) begin
            fwdB = ALU_Result_ex_mem;
        end else if (RegWrite_mem_wb && (dstn_mem_wb != 5'd0) &&
                     (dstn_mem_wb == rt_rr_ex)) begin
            fwdB = Write_Data_wb;
        end

        opB = ALUSrc_rr_ex ? extended_rr_ex : fwdB;
    end

    // ALU and R-type decode. Arithmetic wraps silently; unknown funct codes
    // produce 0 and suppress the register write.
    always_comb begin
        aluResult  = 32'd0;
        functValid = 1'b1;
        isMult     = 1'b0;
        multSigned = 1'b0;
        case (ALUOp_rr_ex)
            2'b00: aluResult = opA + opB;
            2'b01: aluResult = opA - opB;
            2'b11: aluResult = {31'd0, ($signed(opA) < $signed(opB))};
            default: begin
                case (funct_rr_ex)
                    6'h20, 6'h21: aluResult = opA + opB;
                    6'h22, 6'h23: aluResult = opA - opB;
                    6'h24:        aluResult = opA & opB;
                    6'h25:        aluResult = opA | opB;
                    6'h26:        aluResult = opA ^ opB;
                    6'h27:        aluResult = ~(opA | opB);
                    6'h2A:        aluResult = {31'd0, ($signed(opA) < $signed(opB))};
                    6'h2B:        aluResult = {31'd0, (opA < opB)};
                    6'h10:        aluResult = hi_q;
                    6'h12:        aluResult = lo_q;
                    6'h18: begin
                        isMult     = 1'b1;
                        multSigned = 1'b1;
                    end
                    6'h19:        isMult = 1'b1;
                    default:      functValid = 1'b0;
                endcase
            end
        endcase
    end

    // Signed multiply runs on magnitudes; the sign is reapplied at the end.
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    assign magA = (multSigned && opA[31])  ? (~opA + 32'd1)  : opA;
    assign magB = (multSigned && fwdB[31]) ? (~fwdB + 32'd1) : fwdB;

    // One BUSY iteration: add the shifted multiplicand for each of the
    // MUL_STEP low multiplier bits, then form the signed final product.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) begin
                acc_d = acc_d + (mcand_q << i);
            end
        end
        product_d = negate_q ? (~acc_d + 64'd1) : acc_d;
    end

    // Held during reset so the pipeline is never frozen while it is cleared.
    assign stall_ex = !reset && (((state_q == IDLE) && isMult) || (state_q == BUSY));

    // Multiplier sequencer. DONE exists so the held mult instruction can
    // leave RR/EX without being decoded as a fresh multiply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            negate_q <= 1'b0;
            count_q  <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (isMult) begin
                        mcand_q  <= {32'd0, magA};
                        mplier_q <= magB;
                        acc_q    <= 64'd0;
                        negate_q <= multSigned && (opA[31] ^ fwdB[31]);
                        count_q  <= 6'(MUL_ITER - 1);
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << MUL_STEP;
                    mplier_q <= mplier_q >> MUL_STEP;
                    count_q  <= count_q - 6'd1;
                    if (count_q == 6'd0) begin
                        hi_q    <= product_d[63:32];
                        lo_q    <= product_d[31:0];
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // EX/MEM pipeline register. A stall inserts a bubble; a multiply never
    // writes the register file, so it also retires with all controls low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALU_Result_ex_mem <= 32'd0;
            Write_Data_ex_mem <= 32'd0;
            dstn_ex_mem       <= 5'd0;
            MemRead_ex_mem    <= 1'b0;
            MemWrite_ex_mem   <= 1'b0;
            MemtoReg_ex_mem   <= 1'b0;
            RegWrite_ex_mem   <= 1'b0;
        end else begin
            ALU_Result_ex_mem <= aluResult;
            Write_Data_ex_mem <= fwdB;
            dstn_ex_mem       <= dstn_rr_ex;
            if (stall_ex || isMult) begin
                MemRead_ex_mem  <= 1'b0;
                MemWrite_ex_mem <= 1'b0;
                MemtoReg_ex_mem <= 1'b0;
                RegWrite_ex_mem <= 1'b0;
            end else begin
                MemRead_ex_mem  <= MemRead_rr_ex;
                MemWrite_ex_mem <= MemWrite_rr_ex;
                MemtoReg_ex_mem <= MemtoReg_rr_ex;
                RegWrite_ex_mem <= RegWrite_rr_ex && functValid;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage
// ----------------------------------------------------------------------------
// Testbench for ex_stage. Two instances share one stimulus stream: dutA uses
// MUL_STEP=1 and dutB uses MUL_STEP=4; "sel" picks which one is observed and
// the model follows the observed one (both are reset when switching).
// The reference model tracks forwarding, ALU results, stall length and
// HI/LO with plain arithmetic; directed steps also compare against literal
// expected values.
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rd1, rd2, ext;
    logic [4:0]  rs, rt, dstn;
    logic [5:0]  funct;
    logic [1:0]  aluOp;
    logic        aluSrc, memRead, memWrite, memToReg, regWrite;
    logic        rwWb;
    logic [4:0]  dstnWb;
    logic [31:0] wdWb;

    logic [31:0] aluA, wdA, aluB, wdB;
    logic [4:0]  dstnA, dstnB;
    logic        mrA, mwA, mtrA, rwA, stallA;
    logic        mrB, mwB, mtrB, rwB, stallB;

    logic        sel;
    logic [31:0] obsAlu, obsWd;
    logic [4:0]  obsDstn;
    logic        obsMr, obsMw, obsMtr, obsRw, obsStall;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] mAlu, mWd, mHi, mLo;
    logic [4:0]  mDstn;
    logic        mMr, mMw, mMtr, mRw, mDataValid;
    logic [63:0] mProd;
    int          mBusyLeft;
    bit          mDone;
    bit          prevStall;
    int          mulStep;
    int          stallRun;

    logic [5:0]  functTable [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                     6'h26, 6'h27, 6'h2A, 6'h2B, 6'h10, 6'h12,
                                     6'h18, 6'h19, 6'h3F, 6'h05};

    always #5 clk = ~clk;

    ex_stage #(.MUL_STEP(1)) dutA (
        .clk(clk), .reset(reset),
        .Read_Data_1_rr_ex(rd1), .Read_Data_2_rr_ex(rd2), .extended_rr_ex(ext),
        .rs_rr_ex(rs), .rt_rr_ex(rt), .dstn_rr_ex(dstn), .funct_rr_ex(funct),
        .ALUOp_rr_ex(aluOp), .ALUSrc_rr_ex(aluSrc),
        .MemRead_rr_ex(memRead), .MemWrite_rr_ex(memWrite),
        .MemtoReg_rr_ex(memToReg), .RegWrite_rr_ex(regWrite),
        .RegWrite_mem_wb(rwWb), .dstn_mem_wb(dstnWb), .Write_Data_wb(wdWb),
        .ALU_Result_ex_mem(aluA), .Write_Data_ex_mem(wdA), .dstn_ex_mem(dstnA),
        .MemRead_ex_mem(mrA), .MemWrite_ex_mem(mwA), .MemtoReg_ex_mem(mtrA),
        .RegWrite_ex_mem(rwA), .stall_ex(stallA)
    );

    ex_stage #(.MUL_STEP(4)) dutB (
        .clk(clk), .reset(reset),
        .Read_Data_1_rr_ex(rd1), .Read_Data_2_rr_ex(rd2), .extended_rr_ex(ext),
        .rs_rr_ex(rs), .rt_rr_ex(rt), .dstn_rr_ex(dstn), .funct_rr_ex(funct),
        .ALUOp_rr_ex(aluOp), .ALUSrc_rr_ex(aluSrc),
        .MemRead_rr_ex(memRead), .MemWrite_rr_ex(memWrite),
        .MemtoReg_rr_ex(memToReg), .RegWrite_rr_ex(regWrite),
        .RegWrite_mem_wb(rwWb), .dstn_mem_wb(dstnWb), .Write_Data_wb(wdWb),
        .ALU_Result_ex_mem(aluB), .Write_Data_ex_mem(wdB), .dstn_ex_mem(dstnB),
        .MemRead_ex_mem(mrB), .MemWrite_ex_mem(mwB), .MemtoReg_ex_mem(mtrB),
        .RegWrite_ex_mem(rwB), .stall_ex(stallB)
    );

    assign obsAlu   = sel ? aluB   : aluA;
    assign obsWd    = sel ? wdB    : wdA;
    assign obsDstn  = sel ? dstnB  : dstnA;
    assign obsMr    = sel ? mrB    : mrA;
    assign obsMw    = sel ? mwB    : mwA;
    assign obsMtr   = sel ? mtrB   : mtrA;
    assign obsRw    = sel ? rwB    : rwA;
    assign obsStall = sel ? stallB : stallA;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        mAlu = 32'd0; mWd = 32'd0; mHi = 32'd0; mLo = 32'd0; mDstn = 5'd0;
        mMr = 1'b0; mMw = 1'b0; mMtr = 1'b0; mRw = 1'b0; mDataValid = 1'b1;
        mProd = 64'd0; mBusyLeft = 0; mDone = 1'b0; prevStall = 1'b0;
        mulStep = sel ? 4 : 1;
    endtask

    function automatic logic [31:0] modelForward(input logic [4:0] src,
                                                 input logic [31:0] rrVal);
        if (mRw && !mMr && mDstn != 5'd0 && mDstn == src) return mAlu;
        if (rwWb && dstnWb != 5'd0 && dstnWb == src) return wdWb;
        return rrVal;
    endfunction

    function automatic logic [31:0] modelAlu(input logic [31:0] a, input logic [31:0] b,
                                             output bit valid);
        valid = 1'b1;
        case (aluOp)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: begin
                case (funct)
                    6'h20, 6'h21: return a + b;
                    6'h22, 6'h23: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h26: return a ^ b;
                    6'h27: return ~(a | b);
                    6'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    6'h2B: return (a < b) ? 32'd1 : 32'd0;
                    6'h10: return mHi;
                    6'h12: return mLo;
                    6'h18, 6'h19: return 32'd0;
                    default: begin
                        valid = 1'b0;
                        return 32'd0;
                    end
                endcase
            end
        endcase
    endfunction

    task automatic setInstr(input logic [1:0] op, input logic [5:0] fn,
                            input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                            input logic src, input logic r, input logic w,
                            input logic m2r, input logic wr);
        aluOp = op; funct = fn; rs = s; rt = t; dstn = d;
        rd1 = a; rd2 = b; ext = im; aluSrc = src;
        memRead = r; memWrite = w; memToReg = m2r; regWrite = wr;
    endtask

    task automatic setWb(input logic wr, input logic [4:0] d, input logic [31:0] data);
        rwWb = wr; dstnWb = d; wdWb = data;
    endtask

    // One pipeline cycle: entered at a negedge with inputs applied, checks
    // stall before the edge and the EX/MEM register after it.
    task automatic applyStimulus();
        logic [31:0] fa, fb, b, res;
        bit valid, isMult, expStall;
        fa = modelForward(rs, rd1);
        fb = modelForward(rt, rd2);
        b = aluSrc ? ext : fb;
        isMult = (aluOp == 2'b10) && (funct == 6'h18 || funct == 6'h19);
        if (mDone) expStall = 1'b0;
        else if (mBusyLeft > 0) expStall = 1'b1;
        else expStall = isMult;
        res = modelAlu(fa, b, valid);
        #1;
        checkOutput("stall_ex", 32'(obsStall), 32'(expStall));
        if (obsStall) stallRun++;
        @(posedge clk);
        #1;
        if (expStall) begin
            mMr = 1'b0; mMw = 1'b0; mMtr = 1'b0; mRw = 1'b0; mDataValid = 1'b0;
            if (mBusyLeft == 0) begin
                if (funct == 6'h18) mProd = longint'(int'(fa)) * longint'(int'(fb));
                else mProd = {32'd0, fa} * {32'd0, fb};
                mBusyLeft = 32 / mulStep;
            end else begin
                mBusyLeft--;
                if (mBusyLeft == 0) begin
                    mHi = mProd[63:32];
                    mLo = mProd[31:0];
                    mDone = 1'b1;
                end
            end
        end else begin
            mDone = 1'b0;
            mDstn = dstn;
            if (isMult) begin
                mMr = 1'b0; mMw = 1'b0; mMtr = 1'b0; mRw = 1'b0; mDataValid = 1'b0;
            end else begin
                mAlu = res; mWd = fb;
                mMr = memRead; mMw = memWrite; mMtr = memToReg;
                mRw = regWrite && valid;
                mDataValid = 1'b1;
            end
        end
        prevStall = expStall;
        checkOutput("MemRead_ex_mem", 32'(obsMr), 32'(mMr));
        checkOutput("MemWrite_ex_mem", 32'(obsMw), 32'(mMw));
        checkOutput("MemtoReg_ex_mem", 32'(obsMtr), 32'(mMtr));
        checkOutput("RegWrite_ex_mem", 32'(obsRw), 32'(mRw));
        if (mDataValid) begin
            checkOutput("ALU_Result_ex_mem", obsAlu, mAlu);
            checkOutput("Write_Data_ex_mem", obsWd, mWd);
            checkOutput("dstn_ex_mem", 32'(obsDstn), 32'(mDstn));
        end
        @(negedge clk);
    endtask

    task automatic runMult(input bit isSigned, input logic [31:0] a, input logic [31:0] b);
        setInstr(2'b10, isSigned ? 6'h18 : 6'h19, 5'd11, 5'd12, 5'd0, a, b, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        setWb(1'b0, 5'd0, 32'd0);
        stallRun = 0;
        applyStimulus();
        for (int i = 0; i < 64 && prevStall; i++) applyStimulus();
        checkOutput("stall_len", 32'(stallRun), 32'(1 + 32 / mulStep));
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h7FFFFFFF;
            4: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic randomStep();
        if (!prevStall) begin
            aluOp    = 2'($urandom_range(0, 3));
            funct    = functTable[$urandom_range(0, 15)];
            rs       = 5'($urandom_range(0, 7));
            rt       = 5'($urandom_range(0, 7));
            dstn     = 5'($urandom_range(0, 7));
            rd1      = pickOperand();
            rd2      = pickOperand();
            ext      = pickOperand();
            aluSrc   = 1'($urandom_range(0, 1));
            memRead  = ($urandom_range(0, 3) == 0);
            memWrite = ($urandom_range(0, 3) == 0);
            memToReg = memRead;
            regWrite = 1'($urandom_range(0, 1));
        end
        rwWb   = 1'($urandom_range(0, 1));
        dstnWb = 5'($urandom_range(0, 7));
        wdWb   = $urandom;
        applyStimulus();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_alu"}, obsAlu, 32'd0);
        checkOutput({tag, "_wd"}, obsWd, 32'd0);
        checkOutput({tag, "_dstn"}, 32'(obsDstn), 32'd0);
        checkOutput({tag, "_ctrl"}, 32'({obsMr, obsMw, obsMtr, obsRw}), 32'd0);
        checkOutput({tag, "_stall"}, 32'(obsStall), 32'd0);
    endtask

    initial begin
        // Power-on reset observing the MUL_STEP=1 instance
        sel = 1'b0;
        reset = 1'b1;
        setInstr(2'b00, 6'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        setWb(1'b0, 5'd0, 32'd0);
        resetModel();
        repeat (2) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;

        // Forward priority: EX/MEM beats MEM/WB
        setInstr(2'b00, 6'h00, 5'd1, 5'd0, 5'd5, 32'h10, 32'd0, 32'd1,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        setInstr(2'b10, 6'h20, 5'd5, 5'd0, 5'd6, 32'h99, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        setWb(1'b1, 5'd5, 32'h22);
        applyStimulus();
        checkOutput("fwd_exmem", obsAlu, 32'h11);

        // Register $0 is never a forwarding source
        setInstr(2'b00, 6'h00, 5'd1, 5'd0, 5'd0, 32'h10, 32'd0, 32'd1,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        setWb(1'b0, 5'd0, 32'd0);
        applyStimulus();
        setInstr(2'b10, 6'h20, 5'd0, 5'd0, 5'd6, 32'h33, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        setWb(1'b1, 5'd0, 32'h22);
        applyStimulus();
        checkOutput("fwd_zero", obsAlu, 32'h33);

        // ALU sweep
        setWb(1'b0, 5'd0, 32'd0);
        setInstr(2'b10, 6'h2A, 5'd1, 5'd2, 5'd6, 32'hFFFFFFFF, 32'd1, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("slt", obsAlu, 32'd1);
        setInstr(2'b10, 6'h2B, 5'd1, 5'd2, 5'd6, 32'hFFFFFFFF, 32'd1, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("sltu", obsAlu, 32'd0);
        setInstr(2'b10, 6'h20, 5'd1, 5'd2, 5'd6, 32'h7FFFFFFF, 32'd1, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("add_wrap", obsAlu, 32'h80000000);
        setInstr(2'b10, 6'h27, 5'd1, 5'd2, 5'd6, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("nor", obsAlu, 32'hFFFFFFFF);
        setInstr(2'b10, 6'h3F, 5'd1, 5'd2, 5'd6, 32'h5, 32'h6, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("unknown_result", obsAlu, 32'd0);
        checkOutput("unknown_regwrite", 32'(obsRw), 32'd0);

        // Signed multiply, one bit per cycle, then read LO/HI
        runMult(1'b1, 32'hFFFFFFFD, 32'd7);
        setInstr(2'b10, 6'h12, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("mflo_signed", obsAlu, 32'hFFFFFFEB);
        setInstr(2'b10, 6'h10, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("mfhi_signed", obsAlu, 32'hFFFFFFFF);

        // Reset in the middle of BUSY
        setInstr(2'b10, 6'h18, 5'd11, 5'd12, 5'd0, 32'h1234, 32'h5678, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        repeat (10) applyStimulus();
        reset = 1'b1;
        #1;
        checkResetState("midmul_reset");
        setInstr(2'b10, 6'h10, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        resetModel();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus();
        checkOutput("mfhi_after_reset", obsAlu, 32'd0);
        setInstr(2'b10, 6'h12, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("mflo_after_reset", obsAlu, 32'd0);
        runMult(1'b1, 32'd100, 32'hFFFFFFFE);
        setInstr(2'b10, 6'h12, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("mflo_rerun", obsAlu, 32'hFFFFFF38);

        // Store with rt forwarded from WB
        setInstr(2'b00, 6'h00, 5'd3, 5'd9, 5'd0, 32'h1000, 32'hDEAD, 32'h10,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        setWb(1'b1, 5'd9, 32'hCAFE);
        applyStimulus();
        checkOutput("sw_data", obsWd, 32'hCAFE);
        checkOutput("sw_addr", obsAlu, 32'h1010);
        checkOutput("sw_memwrite", 32'(obsMw), 32'd1);

        // Random traffic on the MUL_STEP=1 instance
        for (int i = 0; i < 200; i++) randomStep();
        for (int i = 0; i < 64 && prevStall; i++) randomStep();

        // Switch to the MUL_STEP=4 instance
        sel = 1'b1;
        reset = 1'b1;
        setInstr(2'b00, 6'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        setWb(1'b0, 5'd0, 32'd0);
        resetModel();
        @(negedge clk);
        checkResetState("reset_step4");
        reset = 1'b0;
        runMult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        setInstr(2'b10, 6'h12, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("mflo_unsigned", obsAlu, 32'h00000001);
        setInstr(2'b10, 6'h10, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("mfhi_unsigned", obsAlu, 32'hFFFFFFFE);

        for (int i = 0; i < 100; i++) randomStep();
        for (int i = 0; i < 64 && prevStall; i++) randomStep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
